instr_fetch: RTL and testbench

Multicycle fetch stage sitting directly upstream of the synchronous instruction ROM. Holds the program counter, drives the ROM word address, absorbs the ROM's one-cycle registered read latency, and presents one captured instruction at a time to the control/decode FSM through a valid/ack handshake. Also accepts branch/jump redirects from execute and, optionally, detects the end-of-test marker word.

---
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Multicycle fetch stage: PC, ROM addressing, one-cycle ROM latency, valid/ack hand-off to decode.
// Define FETCH_HALT_EN to enable end-of-test marker detection and the sticky halted flag.
module instr_fetch #(
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = 32'hc0001073
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
`ifdef FETCH_HALT_EN
    localparam logic [2:0] S_HALT = 3'd4;
`endif

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [ADDR_W-1:0] w_pc_next4;
    logic              w_frozen;

`ifdef FETCH_HALT_EN
    logic r_halted;
    logic r_halt_hit;
    assign w_frozen = (r_state == S_HALT);
    assign halted   = r_halted;
`else
    assign w_frozen = 1'b0;
    assign halted   = 1'b0;
`endif

    assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
    assign w_pc_next4    = r_pc + ADDR_W'(4);

    assign rom_addr    = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;

    // Redirect outranks every state-specific action, including an ack in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
`ifdef FETCH_HALT_EN
            r_halted   <= 1'b0;
            r_halt_hit <= 1'b0;
`endif
        end else if (!w_frozen) begin
            if (redirect_valid) begin
                r_pc    <= w_redirect_pc;
                r_valid <= 1'b0;
                r_state <= S_REQ;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (fetch_en) begin
                            r_state <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_instr    <= rom_data;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_state    <= S_HOLD;
`ifdef FETCH_HALT_EN
                        r_halt_hit <= (rom_data == HALT_WORD);
`endif
                    end
                    S_HOLD: begin
                        if (instr_ack) begin
                            r_valid <= 1'b0;
`ifdef FETCH_HALT_EN
                            if (r_halt_hit) begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end else begin
                                r_pc    <= w_pc_next4;
                                r_state <= fetch_en ? S_REQ : S_IDLE;
                            end
`else
                            r_pc    <= w_pc_next4;
                            r_state <= fetch_en ? S_REQ : S_IDLE;
`endif
                        end
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a latency model.
module tb_instr_fetch;

    localparam int          AW        = 14;
    localparam logic [31:0] HALT_WORD = 32'hc0001073;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic          instr_ack = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] rom_addr;
    logic [AW-1:0] instr_pc;
    logic [31:0]   rom_data;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          halted;

    logic [31:0]   mem [0:(1<<(AW-2))-1];
    int            n_checks = 0;
    int            n_pass = 0;

    // Reference model: PC plus a countdown of cycles until the next word is presented.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ipc;
    logic [31:0]   m_instr;
    bit            m_valid;
    bit            m_idle;
    bit            m_halted;
    int            m_wait;

    instr_fetch #(
        .ADDR_W   (AW),
        .RESET_PC ('0),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ack     (instr_ack),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr[AW-1:2]];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_pc = '0; m_ipc = '0; m_instr = '0;
        m_valid = 0; m_idle = 1; m_halted = 0; m_wait = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return 1 ns after the edge.
    task automatic cyc(input bit fe, input bit ack, input bit rv, input logic [AW-1:0] rpc);
        @(negedge clk);
        fetch_en = fe; instr_ack = ack; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        if (!m_halted) begin
            if (rv) begin
                m_pc = {rpc[AW-1:2], 2'b00};
                m_valid = 0; m_idle = 0; m_wait = 2;
            end else if (m_valid) begin
                if (ack) begin
                    m_valid = 0;
                    if (HALT_EN && m_instr == HALT_WORD) m_halted = 1;
                    else begin
                        m_pc = m_pc + AW'(4);
                        if (fe) m_wait = 2; else m_idle = 1;
                    end
                end
            end else if (m_idle) begin
                if (fe) begin m_idle = 0; m_wait = 2; end
            end else begin
                m_wait = m_wait - 1;
                if (m_wait == 0) begin
                    m_valid = 1; m_instr = mem[m_pc[AW-1:2]]; m_ipc = m_pc;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", instr_valid); else n_pass++;
        n_checks++; if (rom_addr !== 14'h0) $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else n_pass++;
        n_checks++; if (instr_pc !== 14'h0) $display("FAIL reset_instr_pc: got %h want 0", instr_pc); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %0b want 0", halted); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL ff_req_valid: got %0b want 0", instr_valid); else n_pass++;
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL ff_wait_valid: got %0b want 0", instr_valid); else n_pass++;
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL ff_valid: got %0b want 1", instr_valid); else n_pass++;
        n_checks++; if (instr !== 32'h00200193) $display("FAIL ff_instr: got %h want 00200193", instr); else n_pass++;
        n_checks++; if (instr_pc !== 14'h0) $display("FAIL ff_instr_pc: got %h want 0000", instr_pc); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, '0);
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h00200193 || instr_pc !== 14'h0 || rom_addr !== 14'h0)
                $display("FAIL stall_hold %0d: got v=%0b instr=%h pc=%h addr=%h want v=1 instr=00200193 pc=0000 addr=0000",
                         i, instr_valid, instr, instr_pc, rom_addr);
            else n_pass++;
        end
        cyc(1, 1, 0, '0);
        n_checks++; if (rom_addr !== 14'h4) $display("FAIL ff_next_addr: got %h want 0004", rom_addr); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL ff_ack_valid: got %0b want 0", instr_valid); else n_pass++;
    endtask

    task automatic test_redirect();
        cyc(1, 0, 0, '0);
        cyc(1, 0, 1, 14'h0296);
        n_checks++; if (rom_addr !== 14'h0294) $display("FAIL rd_wait_addr: got %h want 0294", rom_addr); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0 || instr_pc !== 14'h0)
            $display("FAIL rd_wait_discard: got v=%0b pc=%h want v=0 pc=0000", instr_valid, instr_pc); else n_pass++;
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 14'h0294 || instr !== mem[14'h0294 >> 2])
            $display("FAIL rd_wait_word: got v=%0b pc=%h instr=%h want v=1 pc=0294 instr=%h",
                     instr_valid, instr_pc, instr, mem[14'h0294 >> 2]); else n_pass++;
        cyc(1, 0, 1, 14'h0008);
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 14'h0008)
            $display("FAIL rd_hold_pc8: got v=%0b pc=%h want v=1 pc=0008", instr_valid, instr_pc); else n_pass++;
        cyc(1, 1, 1, 14'h0040);
        n_checks++; if (rom_addr !== 14'h0040) $display("FAIL rd_ack_prio: got %h want 0040", rom_addr); else n_pass++;
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 14'h0040)
            $display("FAIL rd_ack_prio_word: got v=%0b pc=%h want v=1 pc=0040", instr_valid, instr_pc); else n_pass++;
        cyc(0, 0, 1, 14'h0100);
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 14'h0100)
            $display("FAIL rd_fe0_hold: got v=%0b pc=%h want v=1 pc=0100", instr_valid, instr_pc); else n_pass++;
        cyc(0, 1, 0, '0);
        cyc(0, 0, 0, '0);
        cyc(0, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b0 || rom_addr !== 14'h0104)
            $display("FAIL rd_fe0_idle: got v=%0b addr=%h want v=0 addr=0104", instr_valid, rom_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        cyc(1, 0, 1, 14'h3fff);
        n_checks++; if (rom_addr !== 14'h3ffc) $display("FAIL wrap_align: got %h want 3ffc", rom_addr); else n_pass++;
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 14'h3ffc)
            $display("FAIL wrap_word: got v=%0b pc=%h want v=1 pc=3ffc", instr_valid, instr_pc); else n_pass++;
        cyc(1, 1, 0, '0);
        n_checks++; if (rom_addr !== 14'h0000) $display("FAIL wrap_addr: got %h want 0000", rom_addr); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit fe, ack, rv;
            logic [AW-1:0] rpc;
            fe  = ($urandom_range(0, 9) < 8);
            ack = ($urandom_range(0, 1) == 1);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = AW'($urandom);
            cyc(fe, ack, rv, rpc);
            n_checks++; if (instr_valid !== m_valid) $display("FAIL rnd_valid %0d: got %0b want %0b", i, instr_valid, m_valid); else n_pass++;
            n_checks++; if (rom_addr !== m_pc) $display("FAIL rnd_rom_addr %0d: got %h want %h", i, rom_addr, m_pc); else n_pass++;
            n_checks++; if (instr !== m_instr) $display("FAIL rnd_instr %0d: got %h want %h", i, instr, m_instr); else n_pass++;
            n_checks++; if (instr_pc !== m_ipc) $display("FAIL rnd_instr_pc %0d: got %h want %h", i, instr_pc, m_ipc); else n_pass++;
            n_checks++; if (halted !== m_halted) $display("FAIL rnd_halted %0d: got %0b want %0b", i, halted, m_halted); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 1, 14'h0080);
        cyc(1, 0, 0, '0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (instr_valid !== 1'b0 || rom_addr !== 14'h0 || instr !== 32'h0 || instr_pc !== 14'h0)
            $display("FAIL mid_reset: got v=%0b addr=%h instr=%h pc=%h want all zero",
                     instr_valid, rom_addr, instr, instr_pc); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        fetch_en = 1'b0; instr_ack = 1'b0; redirect_valid = 1'b0;
        rst = 1'b0;
        cyc(0, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b0 || rom_addr !== 14'h0)
            $display("FAIL mid_reset_after: got v=%0b addr=%h want v=0 addr=0000", instr_valid, rom_addr); else n_pass++;
    endtask

    task automatic test_halt();
        mem[14'h02d0 >> 2] = HALT_WORD;
        mem[14'h02d4 >> 2] = 32'h00100093;
        cyc(1, 0, 1, 14'h02d0);
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b1 || instr !== HALT_WORD || instr_pc !== 14'h02d0)
            $display("FAIL halt_present: got v=%0b instr=%h pc=%h want v=1 instr=%h pc=02d0",
                     instr_valid, instr, instr_pc, HALT_WORD); else n_pass++;
        cyc(1, 1, 0, '0);
`ifdef FETCH_HALT_EN
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_flag: got %0b want 1", halted); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, 14'h0100);
            n_checks++; if (rom_addr !== 14'h02d0 || halted !== 1'b1 || instr_valid !== 1'b0)
                $display("FAIL halt_frozen %0d: got addr=%h halted=%0b v=%0b want addr=02d0 halted=1 v=0",
                         i, rom_addr, halted, instr_valid); else n_pass++;
        end
`else
        n_checks++; if (halted !== 1'b0 || rom_addr !== 14'h02d4)
            $display("FAIL halt_disabled: got halted=%0b addr=%h want halted=0 addr=02d4", halted, rom_addr); else n_pass++;
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 14'h02d4 || instr !== 32'h00100093)
            $display("FAIL halt_disabled_next: got v=%0b pc=%h instr=%h want v=1 pc=02d4 instr=00100093",
                     instr_valid, instr_pc, instr); else n_pass++;
`endif
    endtask

    initial begin
        for (int i = 0; i < (1 << (AW - 2)); i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT_WORD) mem[i] = 32'h0;
        end
        mem[0] = 32'h00200193;
        test_reset();
        test_first_fetch();
        test_redirect();
        test_wrap();
        test_random();
        test_reset_mid();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
